// File: rtl/harmonic_sequencer.sv
// harmonic_sequencer: shares one CORDIC sine x amplitude unit across HARMONIC
// harmonics. Each sample tick advances the fundamental phase, issues angle
// (k+1)*phase and amp[k] for k = 0..HARMONIC-1, sums the returned products
// and emits the scaled sum as one DAC sample with a valid pulse.
//
// Optional build macro: HARMONIC_SKIP_ZERO_EN
//   defined   -> harmonics whose amplitude is zero are not sent to the shared
//                unit; each one costs a single cycle instead of a round trip.
//   undefined -> every harmonic is issued, so sample latency is fixed.
//
// state | meaning
// IDLE  | waiting for sample_tick_i, busy_o low
// ISSUE | present angle/amplitude of harmonic k to the shared unit
// WAIT  | waiting for the shared unit's result for harmonic k
// DONE  | publish the scaled sum and pulse sample_valid_o

module harmonic_sequencer #(
  parameter int WIDTH    = 24,
  parameter int HARMONIC = 16,
  parameter int LOG2H    = $clog2(HARMONIC)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_tick_i,
  input  logic [WIDTH-1:0] phase_inc_i,
  input  logic             amp_we_i,
  input  logic [LOG2H-1:0] amp_addr_i,
  input  logic [WIDTH-1:0] amp_data_i,
  output logic             cordic_send_o,
  output logic [WIDTH-1:0] cordic_angle_o,
  output logic [WIDTH-1:0] cordic_amp_o,
  input  logic             cordic_valid_i,
  input  logic [WIDTH-1:0] cordic_result_i,
  output logic [WIDTH-1:0] sound_dac_o,
  output logic             sample_valid_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int ACC_W = WIDTH + LOG2H;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [WIDTH-1:0]         phase_acc_q, phase_acc_d;
  logic [WIDTH-1:0]         phase_q, phase_d;
  logic [WIDTH-1:0]         h_angle_q, h_angle_d;
  logic [LOG2H-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]         amp_hold_q, amp_hold_d;
  logic [WIDTH-1:0]         dac_q, dac_d;
  logic                     valid_q, valid_d;
  logic                     overrun_q, overrun_d;
  logic [WIDTH-1:0]         amp_q [HARMONIC];
  logic [WIDTH-1:0]         amp_d [HARMONIC];

  logic [WIDTH-1:0]         cur_amp;
  logic                     k_last;
  logic                     send_c;
`ifdef HARMONIC_SKIP_ZERO_EN
  logic                     amp_zero;
`endif

  assign cur_amp = amp_q[k_q];
  assign k_last  = (k_q == LOG2H'(HARMONIC - 1));
`ifdef HARMONIC_SKIP_ZERO_EN
  assign amp_zero = (cur_amp == '0);
`endif

  // Amplitude table write port; a write lands one cycle after the strobe.
  always_comb begin
    amp_d = amp_q;
    if (amp_we_i) begin
      amp_d[amp_addr_i] = amp_data_i;
    end
  end

  // Amplitude table registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < HARMONIC; i++) begin
        amp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < HARMONIC; i++) begin
        amp_q[i] <= amp_d[i];
      end
    end
  end

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    phase_acc_d = phase_acc_q;
    phase_d     = phase_q;
    h_angle_d   = h_angle_q;
    k_d         = k_q;
    acc_d       = acc_q;
    amp_hold_d  = amp_hold_q;
    dac_d       = dac_q;
    valid_d     = 1'b0;
    overrun_d   = overrun_q;
    send_c      = 1'b0;

    // A tick while a sample is in flight (DONE included) is dropped and
    // flagged; the flag is sticky until reset.
    if (sample_tick_i && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (sample_tick_i) begin
          phase_d     = phase_acc_q;
          phase_acc_d = phase_acc_q + phase_inc_i;
          h_angle_d   = phase_acc_q;
          k_d         = '0;
          acc_d       = '0;
          state_d     = S_ISSUE;
        end
      end

      S_ISSUE: begin
`ifdef HARMONIC_SKIP_ZERO_EN
        if (amp_zero) begin
          // Silent harmonic: skip the round trip, contribute nothing.
          if (k_last) begin
            state_d = S_DONE;
          end else begin
            k_d       = k_q + LOG2H'(1);
            h_angle_d = h_angle_q + phase_q;
          end
        end else begin
          send_c     = 1'b1;
          amp_hold_d = cur_amp;
          state_d    = S_WAIT;
        end
`else
        send_c     = 1'b1;
        amp_hold_d = cur_amp;
        state_d    = S_WAIT;
`endif
      end

      S_WAIT: begin
        // Results outside WAIT (e.g. stale ones after a reset) never reach here.
        if (cordic_valid_i) begin
          acc_d = acc_q + ACC_W'(signed'(cordic_result_i));
          if (k_last) begin
            state_d = S_DONE;
          end else begin
            k_d       = k_q + LOG2H'(1);
            h_angle_d = h_angle_q + phase_q;
            state_d   = S_ISSUE;
          end
        end
      end

      S_DONE: begin
        // Dividing by HARMONIC brings the guard-bit sum back to sample range.
        dac_d   = WIDTH'(acc_q >>> LOG2H);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      phase_acc_q <= '0;
      phase_q     <= '0;
      h_angle_q   <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      amp_hold_q  <= '0;
      dac_q       <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_acc_q <= phase_acc_d;
      phase_q     <= phase_d;
      h_angle_q   <= h_angle_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      amp_hold_q  <= amp_hold_d;
      dac_q       <= dac_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // h_angle_q only moves on the way into ISSUE, so it already holds the angle
  // until the next issue. The amplitude is read from the table during ISSUE
  // (a same-cycle write is not yet visible) and held afterwards.
  always_comb begin
    cordic_send_o  = send_c;
    cordic_angle_o = h_angle_q;
    cordic_amp_o   = (state_q == S_ISSUE) ? cur_amp : amp_hold_q;
    sound_dac_o    = dac_q;
    sample_valid_o = valid_q;
    busy_o         = (state_q != S_IDLE);
    overrun_o      = overrun_q;
  end

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Directed bench for harmonic_sequencer with a 3-cycle model of the shared
// CORDIC x amplitude unit. The model returns the issued amplitude, or a
// forced constant when force_en is set.

module tb_harmonic_sequencer;

  localparam int W = 24;
  localparam int H = 16;
  localparam int L = 3;
`ifdef HARMONIC_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          sample_tick_i = 1'b0;
  logic [W-1:0]  phase_inc_i = '0;
  logic          amp_we_i = 1'b0;
  logic [3:0]    amp_addr_i = '0;
  logic [W-1:0]  amp_data_i = '0;
  logic          cordic_send_o;
  logic [W-1:0]  cordic_angle_o;
  logic [W-1:0]  cordic_amp_o;
  logic          cordic_valid_i;
  logic [W-1:0]  cordic_result_i;
  logic [W-1:0]  sound_dac_o;
  logic          sample_valid_o;
  logic          busy_o;
  logic          overrun_o;

  harmonic_sequencer #(.WIDTH(W), .HARMONIC(H)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sample_tick_i   (sample_tick_i),
    .phase_inc_i     (phase_inc_i),
    .amp_we_i        (amp_we_i),
    .amp_addr_i      (amp_addr_i),
    .amp_data_i      (amp_data_i),
    .cordic_send_o   (cordic_send_o),
    .cordic_angle_o  (cordic_angle_o),
    .cordic_amp_o    (cordic_amp_o),
    .cordic_valid_i  (cordic_valid_i),
    .cordic_result_i (cordic_result_i),
    .sound_dac_o     (sound_dac_o),
    .sample_valid_o  (sample_valid_o),
    .busy_o          (busy_o),
    .overrun_o       (overrun_o)
  );

  always #5 clk = ~clk;

  // Shared unit model: fixed latency L from send to valid.
  logic [2:0]   sp = '0;
  logic [W-1:0] ap0 = '0, ap1 = '0, ap2 = '0;
  logic         valid_force = 1'b0;
  logic         force_en = 1'b0;
  logic [W-1:0] force_val = '0;

  always @(posedge clk) begin
    sp  <= {sp[1:0], cordic_send_o};
    ap0 <= cordic_amp_o;
    ap1 <= ap0;
    ap2 <= ap1;
  end

  assign cordic_valid_i  = sp[2] | valid_force;
  assign cordic_result_i = force_en ? force_val : ap2;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [W-1:0] amp_m [H];
  logic [W-1:0] phase_acc_m = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_amp(input int idx, input logic [W-1:0] val);
    @(negedge clk);
    amp_we_i   = 1'b1;
    amp_addr_i = 4'(idx);
    amp_data_i = val;
    amp_m[idx] = val;
    @(negedge clk);
    amp_we_i   = 1'b0;
  endtask

  // One full sample: expected angles, amplitudes, latency and DAC value come
  // from the bench's amplitude table and phase model.
  task automatic run_sample(input string tag, input logic [W-1:0] inc);
    logic [W-1:0] phase;
    logic [W-1:0] ang;
    logic [W-1:0] exp_ang [$];
    logic [W-1:0] exp_amp [$];
    logic [W-1:0] exp_dac;
    logic [W-1:0] dac;
    longint       sum;
    int           cnt, nsent, bad_ang, bad_amp, lat, exp_lat, n;
    phase       = phase_acc_m;
    phase_acc_m = phase_acc_m + inc;
    ang = phase;
    sum = 0;
    for (int k = 0; k < H; k++) begin
      ang = W'(phase * (k + 1));
      if (!SKIP || amp_m[k] != '0) begin
        exp_ang.push_back(ang);
        exp_amp.push_back(amp_m[k]);
        sum += force_en ? longint'(signed'(force_val)) : longint'(signed'(amp_m[k]));
      end
    end
    n       = exp_ang.size();
    exp_lat = 2 + n * (L + 1) + (H - n);
    exp_dac = W'(sum >>> 4);
    dac     = '0;
    nsent = 0; bad_ang = 0; bad_amp = 0; lat = -1; cnt = 0;
    @(negedge clk);
    phase_inc_i   = inc;
    sample_tick_i = 1'b1;
    while (lat < 0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
      sample_tick_i = 1'b0;
      if (cordic_send_o) begin
        if (nsent < n) begin
          if (cordic_angle_o !== exp_ang[nsent]) bad_ang++;
          if (cordic_amp_o !== exp_amp[nsent]) bad_amp++;
        end
        nsent++;
      end
      if (sample_valid_o) begin
        lat = cnt;
        dac = sound_dac_o;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " sends"}, 64'(nsent), 64'(n));
    check({tag, " angle_errs"}, 64'(bad_ang), 64'd0);
    check({tag, " amp_errs"}, 64'(bad_amp), 64'd0);
    check({tag, " dac"}, 64'(dac), 64'(exp_dac));
  endtask

  initial begin
    int cnt, pulses, bad;
    logic busy5;
    logic [W-1:0] phase;

    for (int k = 0; k < H; k++) amp_m[k] = '0;

    // Reset state
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst dac", 64'(sound_dac_o), 64'd0);
    check("rst valid", 64'(sample_valid_o), 64'd0);
    check("rst send", 64'(cordic_send_o), 64'd0);
    check("rst busy", 64'(busy_o), 64'd0);
    check("rst overrun", 64'(overrun_o), 64'd0);
    check("rst angle", 64'(cordic_angle_o), 64'd0);
    check("rst amp", 64'(cordic_amp_o), 64'd0);
    reset_n = 1'b1;

    // Stray valid while idle must do nothing
    @(negedge clk);
    valid_force = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy_o || sample_valid_o || cordic_send_o) bad++;
    end
    valid_force = 1'b0;
    check("idle stray valid", 64'(bad), 64'd0);

    // Single harmonic, phase starts at 0
    write_amp(0, 24'h100000);
    run_sample("single", 24'h010000);
    // Angle ramp k*0x010000
    run_sample("angles", 24'h010000);

    for (int k = 0; k < H; k++) write_amp(k, W'((k + 1) * 24'h010000));
    // phase 0x020000, moves accumulator to 0x800000
    run_sample("ramp", 24'h7E0000);
    // phase 0x800000: angles alternate 0x800000 / 0x000000
    run_sample("wrap", 24'h800000);

    // Extreme results, no accumulator wrap
    force_en  = 1'b1;
    force_val = 24'h800000;
    run_sample("most_neg", 24'h000100);
    force_val = 24'h7FFFFF;
    run_sample("most_pos", 24'h000100);
    force_en  = 1'b0;

    // Overrun: second tick 5 cycles into the sample
    check("ovr before", 64'(overrun_o), 64'd0);
    phase_acc_m = phase_acc_m + 24'h000100;
    @(negedge clk);
    phase_inc_i   = 24'h000100;
    sample_tick_i = 1'b1;
    cnt = 0; pulses = 0; busy5 = 1'b0;
    while (cnt < 100) begin
      @(negedge clk);
      cnt++;
      sample_tick_i = (cnt == 5);
      if (cnt == 5) busy5 = busy_o;
      if (sample_valid_o) pulses++;
    end
    sample_tick_i = 1'b0;
    check("ovr busy_at_2nd_tick", 64'(busy5), 64'd1);
    check("ovr sample_pulses", 64'(pulses), 64'd1);
    check("ovr sticky", 64'(overrun_o), 64'd1);
    // Angles here prove the phase advanced only once
    run_sample("after_ovr", 24'h000100);
    check("ovr still set", 64'(overrun_o), 64'd1);

    // Reset during WAIT of k=7
    phase       = phase_acc_m;
    phase_acc_m = phase_acc_m + 24'h000100;
    @(negedge clk);
    phase_inc_i   = 24'h000100;
    sample_tick_i = 1'b1;
    cnt = 0;
    while (cnt < 30) begin
      @(negedge clk);
      cnt++;
      sample_tick_i = 1'b0;
    end
    check("mid k7 busy", 64'(busy_o), 64'd1);
    check("mid k7 angle", 64'(cordic_angle_o), 64'(W'(phase * 8)));
    reset_n = 1'b0;
    #1;
    check("mid rst busy", 64'(busy_o), 64'd0);
    check("mid rst send", 64'(cordic_send_o), 64'd0);
    check("mid rst angle", 64'(cordic_angle_o), 64'd0);
    check("mid rst amp", 64'(cordic_amp_o), 64'd0);
    check("mid rst dac", 64'(sound_dac_o), 64'd0);
    check("mid rst overrun", 64'(overrun_o), 64'd0);
    @(negedge clk);
    reset_n     = 1'b1;
    phase_acc_m = '0;
    for (int k = 0; k < H; k++) amp_m[k] = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy_o || sample_valid_o || sound_dac_o != '0) bad++;
    end
    check("stale valid ignored", 64'(bad), 64'd0);

    write_amp(0, 24'h100000);
    run_sample("post_reset", 24'h040000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
